// File: rtl/alu_mac_seq.sv
// alu_mac_seq: multiply-accumulate sequencer for dsp48a1_inst, with rounded and scaled 18-bit result.
// Defining MAC_SATURATE_EN clamps overflowed results; otherwise they wrap and only out_ovf reports the overflow.
module alu_mac_seq #(
  parameter int FRAC_BITS = 16,
  parameter int DSP_LAT   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_a,
  input  logic [17:0] in_b,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_data,
  output logic        out_ovf,
  output logic [7:0]  dsp_op,
  output logic [17:0] dsp_a,
  output logic [17:0] dsp_b,
  output logic [47:0] dsp_c,
  input  logic [47:0] dsp_p
);
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;
  localparam logic [7:0]  OP_FIRST = 8'h0D;
  localparam logic [7:0]  OP_ACC   = 8'h09;
  localparam logic [7:0]  OP_HOLD  = 8'h08;
  localparam logic [47:0] RND      = 48'd1 << (FRAC_BITS - 1);
  localparam int          CW       = $clog2(DSP_LAT + 1) + 1;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic [17:0]     out_data_q, out_data_d, dsp_a_q, dsp_a_d, dsp_b_q, dsp_b_d, s, res;
  logic [7:0]      dsp_op_q, dsp_op_d;
  logic [47:0]     dsp_c_q;
  logic            accept, ovf;
  assign accept = in_valid & in_ready_q;
  assign s      = 18'($signed(dsp_p) >>> FRAC_BITS);
  // the sum fits 18 bits after scaling only if every bit above the result sign agrees with it
  assign ovf    = ~(&dsp_p[47:FRAC_BITS+17] | ~|dsp_p[47:FRAC_BITS+17]);
`ifdef MAC_SATURATE_EN
  assign res    = ovf ? (dsp_p[47] ? 18'h20000 : 18'h1FFFF) : s;
`else
  assign res    = s;
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    dsp_op_d    = accept ? (state_q == IDLE ? OP_FIRST : OP_ACC) : OP_HOLD;
    dsp_a_d     = accept ? in_a : dsp_a_q;
    dsp_b_d     = accept ? in_b : dsp_b_q;
    case (state_q)
      IDLE, ACC: begin
        state_d = accept ? (in_last ? DRAIN : ACC) : state_q;
        cnt_d   = '0;
      end
      DRAIN: begin
        cnt_d       = cnt_q + 1'b1;
        out_valid_d = cnt_q == CW'(DSP_LAT);
        out_data_d  = cnt_q == CW'(DSP_LAT) ? res : out_data_q;
        out_ovf_d   = cnt_q == CW'(DSP_LAT) ? ovf : out_ovf_q;
        state_d     = cnt_q == CW'(DSP_LAT) ? OUT : DRAIN;
      end
      default: begin
        out_valid_d = ~out_ready;
        state_d     = out_ready ? IDLE : OUT;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      dsp_op_q    <= OP_HOLD;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      dsp_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= state_d == IDLE || state_d == ACC;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      dsp_op_q    <= dsp_op_d;
      dsp_a_q     <= dsp_a_d;
      dsp_b_q     <= dsp_b_d;
      dsp_c_q     <= RND;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign dsp_op    = dsp_op_q;
  assign dsp_a     = dsp_a_q;
  assign dsp_b     = dsp_b_q;
  assign dsp_c     = dsp_c_q;
endmodule

// File: tb/tb_alu_mac_seq.sv
// tb_alu_mac_seq: randomized bench for alu_mac_seq with a behavioural DSP48A1 model on dsp_p.
// Expected results come from summing the products directly and applying round/scale/range rules.
module tb_alu_mac_seq;
  localparam int FRAC_BITS = 16;
  localparam int DSP_LAT   = 3;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [17:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, out_ovf;
  logic [17:0] out_data, dsp_a, dsp_b;
  logic [7:0]  dsp_op;
  logic [47:0] dsp_c, dsp_p;
  int          n_cmp = 0, n_err = 0;
  logic [17:0] qa[$], qb[$];
  int          gaps[$];
  logic [7:0]  op_log[$];

  alu_mac_seq #(.FRAC_BITS(FRAC_BITS), .DSP_LAT(DSP_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .dsp_op(dsp_op), .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_p(dsp_p)
  );

  always #5 clk = ~clk;

  // DSP48A1 stand-in: inputs registered, then multiplier register, then P register (DSP_LAT stages)
  logic [7:0]  op_s[DSP_LAT-1];
  logic [47:0] m_s[DSP_LAT-1], c_s[DSP_LAT-1];
  always @(posedge clk) begin
    if (reset) begin
      dsp_p <= '0;
      for (int i = 0; i < DSP_LAT-1; i++) op_s[i] <= 8'h08;
    end else begin
      if (op_s[DSP_LAT-2] == 8'h0D) dsp_p <= c_s[DSP_LAT-2] + m_s[DSP_LAT-2];
      else if (op_s[DSP_LAT-2] == 8'h09) dsp_p <= dsp_p + m_s[DSP_LAT-2];
      op_s[0] <= dsp_op;
      m_s[0]  <= 48'($signed(dsp_a)) * 48'($signed(dsp_b));
      c_s[0]  <= dsp_c;
      for (int i = 1; i < DSP_LAT-1; i++) begin
        op_s[i] <= op_s[i-1];
        m_s[i]  <= m_s[i-1];
        c_s[i]  <= c_s[i-1];
      end
    end
  end

  function automatic longint exp_sum();
    longint acc = 0;
    foreach (qa[i]) acc += longint'($signed(qa[i])) * longint'($signed(qb[i]));
    return acc;
  endfunction

  function automatic void ref_result(input longint sum, output logic [17:0] d, output logic o);
    longint s = (sum + (longint'(1) << (FRAC_BITS-1))) >>> FRAC_BITS;
    o = (s > 131071) || (s < -131072);
`ifdef MAC_SATURATE_EN
    d = o ? (s > 0 ? 18'h1FFFF : 18'h20000) : 18'(s);
`else
    d = 18'(s);
`endif
  endfunction

  task automatic push_beat(input logic [17:0] a, input logic [17:0] b, input logic last,
                           output bit to, output logic [7:0] op);
    int w = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    to = !in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    op = dsp_op;
  endtask

  task automatic drive_sum(output logic [17:0] d, output logic o, output int lat, output bit to, output bit bok);
    bit t;
    logic [7:0] op;
    to = 0; bok = 1; op_log.delete();
    foreach (qa[i]) begin
      repeat (gaps[i]) begin @(posedge clk); #1; if (dsp_op !== 8'h08) bok = 0; end
      push_beat(qa[i], qb[i], i == qa.size()-1, t, op);
      to |= t;
      op_log.push_back(op);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    to |= !out_valid;
    d = out_data; o = out_ovf;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic load(input int n, input logic [17:0] a, input logic [17:0] b, input int gap);
    qa.delete(); qb.delete(); gaps.delete();
    for (int i = 0; i < n; i++) begin qa.push_back(a); qb.push_back(b); gaps.push_back(gap); end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if ({out_data, out_ovf} !== 19'h0) begin n_err++; $display("FAIL reset_out got %h/%b want 0/0", out_data, out_ovf); end
    n_cmp++; if (dsp_op !== 8'h08) begin n_err++; $display("FAIL reset_dsp_op got %h want 08", dsp_op); end
    n_cmp++; if ({dsp_a, dsp_b, dsp_c} !== 84'h0) begin n_err++; $display("FAIL reset_dsp_abc got %h %h %h want 0", dsp_a, dsp_b, dsp_c); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    n_cmp++; if (dsp_c !== 48'h8000) begin n_err++; $display("FAIL dsp_c got %h want 8000", dsp_c); end
  endtask

  task automatic test_one_pair();
    logic [17:0] d; logic o; int lat; bit to, bok;
    load(1, 18'h10000, 18'h10000, 0);
    drive_sum(d, o, lat, to, bok);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL one_pair_timeout got %b want 0", to); end
    n_cmp++; if ({d, o} !== {18'h10000, 1'b0}) begin n_err++; $display("FAIL one_pair_result got %h/%b want 10000/0", d, o); end
    n_cmp++; if (lat !== DSP_LAT+1) begin n_err++; $display("FAIL one_pair_latency got %0d want %0d", lat, DSP_LAT+1); end
    n_cmp++; if (op_log[0] !== 8'h0D) begin n_err++; $display("FAIL one_pair_op got %h want 0d", op_log[0]); end
    take();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL one_pair_handshake got %b%b want 01", out_valid, in_ready); end
  endtask

  task automatic test_bubbles();
    logic [17:0] d; logic o; int lat; bit to, bok;
    for (int g = 0; g < 5; g++) begin
      load(4, 18'h08000, 18'h08000, g);
      if (g == 4) foreach (gaps[i]) gaps[i] = $urandom_range(0, 3);
      drive_sum(d, o, lat, to, bok);
      n_cmp++; if ({to, bok} !== 2'b01) begin n_err++; $display("FAIL bubbles%0d_flow got to=%b hold_ok=%b want 0/1", g, to, bok); end
      n_cmp++; if ({d, o} !== {18'h10000, 1'b0}) begin n_err++; $display("FAIL bubbles%0d_result got %h/%b want 10000/0", g, d, o); end
      take();
    end
  endtask

  task automatic test_overflow();
    logic [17:0] d, ed; logic o, eo; int lat; bit to, bok;
    load(4, 18'h1FFFF, 18'h1FFFF, 0);
    ref_result(exp_sum(), ed, eo);
    drive_sum(d, o, lat, to, bok);
    n_cmp++; if ({d, o} !== {ed, eo} || to) begin n_err++; $display("FAIL overflow got %h/%b want %h/%b", d, o, ed, eo); end
`ifdef MAC_SATURATE_EN
    n_cmp++; if ({d, o} !== {18'h1FFFF, 1'b1}) begin n_err++; $display("FAIL overflow_sat got %h/%b want 1ffff/1", d, o); end
`else
    n_cmp++; if ({d, o} !== {18'h3FFF0, 1'b1}) begin n_err++; $display("FAIL overflow_wrap got %h/%b want 3fff0/1", d, o); end
`endif
    take();
    load(3, 18'h20000, 18'h1FFFF, 0);
    ref_result(exp_sum(), ed, eo);
    drive_sum(d, o, lat, to, bok);
    n_cmp++; if ({d, o} !== {ed, eo} || to) begin n_err++; $display("FAIL overflow_neg got %h/%b want %h/%b", d, o, ed, eo); end
    take();
  endtask

  task automatic test_round();
    logic [17:0] d; logic o; int lat; bit to, bok;
    load(1, 18'h3FFFF, 18'h08000, 0);
    drive_sum(d, o, lat, to, bok);
    n_cmp++; if ({d, o, to} !== {18'h0, 1'b0, 1'b0}) begin n_err++; $display("FAIL round_half_up got %h/%b want 0/0", d, o); end
    take();
  endtask

  task automatic test_backpressure();
    logic [17:0] d, ed; logic o, eo; int lat; bit to, bok;
    load(2, 18'($signed(11'($urandom))), 18'($signed(11'($urandom))), 1);
    ref_result(exp_sum(), ed, eo);
    drive_sum(d, o, lat, to, bok);
    for (int c = 0; c < 6; c++) begin
      in_valid = c[0]; in_a = 18'($urandom); in_b = 18'($urandom); in_last = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, out_data, out_ovf, dsp_op} !== {1'b1, 1'b0, ed, eo, 8'h08}) begin
        n_err++;
        $display("FAIL backpressure%0d got v=%b rdy=%b d=%h o=%b op=%h want v=1 rdy=0 d=%h o=%b op=08",
                 c, out_valid, in_ready, out_data, out_ovf, dsp_op, ed, eo);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    take();
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL backpressure_release got %b%b want 01", out_valid, in_ready); end
    load(1, 18'h10000, 18'h10000, 0);
    drive_sum(d, o, lat, to, bok);
    n_cmp++; if ({d, o, to} !== {18'h10000, 1'b0, 1'b0}) begin n_err++; $display("FAIL backpressure_next got %h/%b want 10000/0", d, o); end
    take();
  endtask

  task automatic test_reset_mid();
    logic [17:0] d; logic o; int lat; bit to, bok, t;
    logic [7:0] op;
    bit seen = 0;
    push_beat(18'h10000, 18'h10000, 1'b0, t, op);
    push_beat(18'h10000, 18'h10000, 1'b0, t, op);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if ({in_ready, out_valid, dsp_op} !== {1'b0, 1'b0, 8'h08}) begin n_err++; $display("FAIL reset_mid_state got rdy=%b v=%b op=%h want 0/0/08", in_ready, out_valid, dsp_op); end
    repeat (10) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_abandon got out_valid=%b want 0", seen); end
    load(1, 18'h10000, 18'h10000, 0);
    drive_sum(d, o, lat, to, bok);
    n_cmp++; if ({d, o, to} !== {18'h10000, 1'b0, 1'b0}) begin n_err++; $display("FAIL reset_mid_new got %h/%b want 10000/0", d, o); end
    take();
  endtask

  task automatic test_random();
    for (int n = 0; n < 16; n++) begin
      logic [17:0] d, ed; logic o, eo; int lat; bit to, bok;
      int len, bad;
      len = $urandom_range(1, 6); bad = 0;
      qa.delete(); qb.delete(); gaps.delete();
      for (int i = 0; i < len; i++) begin
        qa.push_back(n[0] ? 18'($urandom) : 18'($signed(11'($urandom))));
        qb.push_back(n[0] ? 18'($urandom) : 18'($signed(11'($urandom))));
        gaps.push_back($urandom_range(0, 3));
      end
      ref_result(exp_sum(), ed, eo);
      drive_sum(d, o, lat, to, bok);
      foreach (op_log[i]) if (op_log[i] !== (i == 0 ? 8'h0D : 8'h09)) bad++;
      n_cmp++; if ({d, o} !== {ed, eo}) begin n_err++; $display("FAIL random%0d_result got %h/%b want %h/%b", n, d, o, ed, eo); end
      n_cmp++; if ({to, bok} !== 2'b01) begin n_err++; $display("FAIL random%0d_flow got to=%b hold_ok=%b want 0/1", n, to, bok); end
      n_cmp++; if (lat !== DSP_LAT+1) begin n_err++; $display("FAIL random%0d_latency got %0d want %0d", n, lat, DSP_LAT+1); end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL random%0d_ops got %0d bad want 0", n, bad); end
      take();
    end
  endtask

  initial begin
    test_reset();
    test_one_pair();
    test_bubbles();
    test_overflow();
    test_round();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
